// File: rtl/const_burst_pkg.sv
// Shared definitions for the constant-sample burst generator.
// Settings offsets, command bits and FSM encoding.
package const_burst_pkg;

  localparam int unsigned OFF_VALUE = 0;
  localparam int unsigned OFF_LEN   = 1;
  localparam int unsigned OFF_NPKT  = 2;
  localparam int unsigned OFF_CMD   = 3;

  localparam int unsigned CMD_START = 0;
  localparam int unsigned CMD_STOP  = 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

endpackage

// File: rtl/const_burst_regs.sv
// Settings-bus decode: VALUE/LEN/NPKT registers and
// same-cycle start/stop pulses from CMD writes.
module const_burst_regs
  import const_burst_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SR_BASE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  output logic [WIDTH-1:0] value,
  output logic [15:0]      len,
  output logic [15:0]      npkt,
  output logic             start,
  output logic             stop
);

  localparam logic [7:0] A_VALUE = 8'(SR_BASE + OFF_VALUE);
  localparam logic [7:0] A_LEN   = 8'(SR_BASE + OFF_LEN);
  localparam logic [7:0] A_NPKT  = 8'(SR_BASE + OFF_NPKT);
  localparam logic [7:0] A_CMD   = 8'(SR_BASE + OFF_CMD);

  logic is_cmd;

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
      len   <= '0;
      npkt  <= '0;
    end else if (set_stb) begin
      unique case (1'b1)
        (set_addr == A_VALUE): value <= set_data[WIDTH-1:0];
        (set_addr == A_LEN):   len   <= set_data[15:0];
        (set_addr == A_NPKT):  npkt  <= set_data[15:0];
        default: ;
      endcase
    end
  end

  // Stop wins when both command bits are set.
  assign is_cmd = set_stb && (set_addr == A_CMD);
  assign stop   = is_cmd && set_data[CMD_STOP];
  assign start  = is_cmd && set_data[CMD_START]
                         && !set_data[CMD_STOP];

endmodule

// File: rtl/const_burst_ctrl.sv
// Constant-sample packet generator: streams the active VALUE
// in LEN-sample packets, NPKT times or until stopped.
module const_burst_ctrl
  import const_burst_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SR_BASE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             busy,
  output logic [15:0]      pkt_count
);

  logic [WIDTH-1:0] value;
  logic [15:0]      len;
  logic [15:0]      npkt;
  logic             start;
  logic             stop;

  const_burst_regs #(
    .WIDTH  (WIDTH),
    .SR_BASE(SR_BASE)
  ) u_regs (
    .clk     (clk),
    .reset   (reset),
    .set_stb (set_stb),
    .set_addr(set_addr),
    .set_data(set_data),
    .value   (value),
    .len     (len),
    .npkt    (npkt),
    .start   (start),
    .stop    (stop)
  );

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] act_val;
  logic [15:0]      act_len;
  logic [15:0]      cnt;
  logic             start_ok;
  logic             last;
  logic             xfer;
  logic             pkt_done;
  logic             end_run;

  assign start_ok = start && (len != 16'd0);
  assign last     = (cnt == act_len - 16'd1);
  assign xfer     = o_tvalid && o_tready;
  assign pkt_done = xfer && last;
  // Evaluated against the count after this packet and the LEN about to reload.
  assign end_run  = ((npkt != 16'd0) && (pkt_count + 16'd1 == npkt))
                 || (len == 16'd0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start_ok) state_nxt = RUN;
      RUN: begin
        if (pkt_done && (end_run || stop)) state_nxt = IDLE;
        else if (stop)                     state_nxt = STOPPING;
      end
      STOPPING: if (pkt_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      act_val   <= '0;
      act_len   <= '0;
      cnt       <= '0;
      pkt_count <= '0;
    end else if ((state == IDLE) && start_ok) begin
      act_val   <= value;
      act_len   <= len;
      cnt       <= '0;
      pkt_count <= '0;
    end else if (pkt_done) begin
      act_val   <= value;
      act_len   <= len;
      cnt       <= '0;
      pkt_count <= pkt_count + 16'd1;
    end else if (xfer) begin
      cnt <= cnt + 16'd1;
    end
  end

  always_comb begin
    o_tvalid = (state != IDLE);
    busy     = (state != IDLE);
    o_tlast  = (state != IDLE) && last;
    o_tdata  = act_val;
  end

endmodule
